wb_stage_reg: RTL

Parametrised MEM/WB pipeline stage between the memory stage and the register file, carrying up to LANES register-write requests per beat. Unlike a plain stage flop, it uses a valid/ready handshake with a two-entry skid buffer, so writeback back-pressure never drops an instruction. It also supports a synchronous flush, resolves same-address conflicts between lanes, and keeps a retired-write counter for performance monitoring.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_lane_filter.sv | 40 ++++
 rtl/wb_stage_reg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the MEM/WB stage register
package wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_LANES  = 4;
    localparam int ZERO_REG   = 0;

    typedef struct packed {
        logic [MAX_LANES-1:0][ADDR_W_DEF-1:0] waddr;
        logic [MAX_LANES-1:0]                 we;
        logic [MAX_LANES-1:0][DATA_W_DEF-1:0] wdata;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/wb_lane_filter.sv
// rtl/wb_lane_filter.sv - per-beat write-enable filter (lane conflicts; x0 drop under WB_X0_FILTER_EN)
module wb_lane_filter
    import wb_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [LANES*ADDR_W-1:0] waddr,
    input  logic [LANES-1:0]        we,
    output logic [LANES-1:0]        we_filt
);

`ifdef WB_X0_FILTER_EN
    localparam bit X0_FILTER = 1'b1;
`else
    localparam bit X0_FILTER = 1'b0;
`endif

    logic [LANES-1:0] we_live;

    // x0 lanes are dropped before the conflict check so they never shadow an older lane
    always_comb begin
        we_live = we;
        for (int l = 0; l < LANES; l++) begin
            if (X0_FILTER && (waddr[l*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_REG))) begin
                we_live[l] = 1'b0;
            end
        end
        we_filt = we_live;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (we_live[i] && we_live[j] &&
                    (waddr[i*ADDR_W +: ADDR_W] == waddr[j*ADDR_W +: ADDR_W])) begin
                    we_filt[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/wb_stage_reg.sv
// rtl/wb_stage_reg.sv - MEM/WB stage with two-entry skid buffer, flush and retired-write counter (WB_X0_FILTER_EN)
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [LANES*ADDR_W-1:0] reg_waddr_i,
    input  logic [LANES-1:0]        reg_we_i,
    input  logic [LANES*DATA_W-1:0] reg_wdata_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*ADDR_W-1:0] reg_waddr_o,
    output logic [LANES-1:0]        reg_we_o,
    output logic [LANES*DATA_W-1:0] reg_wdata_o,
    output logic [CNT_W-1:0]        retired_cnt_o
);

    typedef struct packed {
        logic [LANES*ADDR_W-1:0] waddr;
        logic [LANES-1:0]        we;
        logic [LANES*DATA_W-1:0] wdata;
    } stage_entry_t;

    stage_state_e state_q, state_d;
    stage_entry_t main_q, skid_q, in_entry;
    logic [LANES-1:0] we_filt;
    logic [CNT_W-1:0] cnt_q, pop;
    logic in_ready_q, main_valid, accept, drain;
    logic load_main_in, load_main_skid, load_skid;

    wb_lane_filter #(.LANES(LANES), .ADDR_W(ADDR_W)) u_filter (
        .waddr   (reg_waddr_i),
        .we      (reg_we_i),
        .we_filt (we_filt)
    );

    always_comb begin
        in_entry.waddr = reg_waddr_i;
        in_entry.we    = we_filt;
        in_entry.wdata = reg_wdata_i;
    end

    assign main_valid = (state_q != ST_EMPTY);
    assign accept     = in_valid_i & in_ready_q;
    assign drain      = main_valid & out_ready_i;

    // in_ready is registered from the next state so it never depends on out_ready_i combinationally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_SKID);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL: begin
                    if (accept && !drain)      state_d = ST_SKID;
                    else if (drain && !accept) state_d = ST_EMPTY;
                end
                ST_SKID:  if (drain) state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush_i) begin
            load_main_in   = accept && ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && drain));
            load_skid      = accept && (state_q == ST_FULL) && !drain;
            load_main_skid = (state_q == ST_SKID) && drain;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
        end
    end

    always_comb begin
        pop = '0;
        for (int l = 0; l < LANES; l++) begin
            pop = pop + CNT_W'(reg_we_o[l]);
        end
    end

    // a drain during flush still counts: the regfile sampled that beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    cnt_q <= '0;
        else if (drain) cnt_q <= cnt_q + pop;
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = main_valid;
    assign reg_waddr_o   = main_q.waddr;
    assign reg_we_o      = main_q.we & {LANES{main_valid}};
    assign reg_wdata_o   = main_q.wdata;
    assign retired_cnt_o = cnt_q;

endmodule
